// File: rtl/time_pkg.sv
// Shared constants and packed-BCD helpers for the time-of-day counter.
// A field is two BCD digits: tens in [7:4] and ones in [3:0].
package time_pkg;

    localparam int FIELD_W = 8;
    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;
    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

    function automatic logic bcd_digit_valid(input logic [3:0] d);
        return d <= BCD_DIGIT_MAX;
    endfunction

    function automatic int bcd_to_int(input logic [FIELD_W-1:0] f);
        return int'(f[7:4]) * 10 + int'(f[3:0]);
    endfunction

    function automatic logic bcd_field_valid(input logic [FIELD_W-1:0] f, input int modulus);
        return bcd_digit_valid(f[7:4]) && bcd_digit_valid(f[3:0]) && (bcd_to_int(f) < modulus);
    endfunction

    // Field 0 is seconds, field 1 is minutes, anything above is hours.
    function automatic int field_modulus(input int idx, input int hour_limit);
        case (idx)
            0:       return SEC_MAX + 1;
            1:       return MIN_MAX + 1;
            default: return hour_limit;
        endcase
    endfunction

endpackage

// File: rtl/bcd_field_counter.sv
// One two-digit packed-BCD field that counts 0..MODULUS-1.
// The carry out is combinational so that a whole chain of fields updates on one edge.
module bcd_field_counter
    import time_pkg::*;
#(
    parameter int MODULUS = 60
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               carry_in,
    output logic               carry_out,
    input  logic               load,
    input  logic [FIELD_W-1:0] load_val,
    output logic [FIELD_W-1:0] value
);

    logic [FIELD_W-1:0] value_q;
    logic [FIELD_W-1:0] value_d;
    logic               at_max;

    always_comb begin
        at_max    = (bcd_to_int(value_q) == MODULUS - 1);
        carry_out = carry_in && at_max;
        // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
        value_d   = value_q;
        if (load) begin
            value_d = load_val;
        end else if (carry_in) begin
            if (at_max) begin
                value_d = '0;
            end else if (value_q[3:0] == BCD_DIGIT_MAX) begin
                value_d = {value_q[7:4] + 4'd1, 4'd0};
            end else begin
                value_d = {value_q[7:4], value_q[3:0] + 4'd1};
            end
        end
    end

    // NOTE: state updates use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (resetn) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/bcd_time_counter.sv
// Packed-BCD MM:SS / HH:MM:SS counter with prescaler, validated loads and an alarm.
// resetn is synchronous and active-high despite its name.
module bcd_time_counter
    import time_pkg::*;
#(
    parameter int NUM_FIELDS = 2,
    parameter int TICK_DIV   = 1,
    parameter int HOUR_LIMIT = 24
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          run,
    input  logic                          load_valid,
    input  logic [FIELD_W*NUM_FIELDS-1:0] load_time,
    input  logic                          alarm_set,
    input  logic [FIELD_W*NUM_FIELDS-1:0] alarm_time,
    input  logic                          alarm_en,
    input  logic                          alarm_ack,
    output logic [FIELD_W*NUM_FIELDS-1:0] time_out,
    output logic                          tick_out,
    output logic                          rollover,
    output logic                          alarm_hit,
    output logic                          alarm_pending,
    output logic                          load_err
);

    localparam int W  = FIELD_W * NUM_FIELDS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]     presc_q, presc_d;
    logic [W-1:0]      alarm_q, alarm_d;
    logic              tick_out_q, tick_out_d;
    logic              rollover_q, rollover_d;
    logic              alarm_hit_q, alarm_hit_d;
    logic              pending_q, pending_d;
    logic              load_err_q, load_err_d;
    logic              load_time_ok, alarm_time_ok;
    logic              load_ok, tick, advance;
    logic [NUM_FIELDS:0] carry;

    always_comb begin
        load_time_ok  = 1'b1;
        alarm_time_ok = 1'b1;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            load_time_ok  &= bcd_field_valid(load_time[i*FIELD_W +: FIELD_W],
                                             field_modulus(i, HOUR_LIMIT));
            alarm_time_ok &= bcd_field_valid(alarm_time[i*FIELD_W +: FIELD_W],
                                             field_modulus(i, HOUR_LIMIT));
        end
    end

    // A valid load takes priority over a same-cycle tick and restarts the prescaler.
    always_comb begin
        load_ok  = load_valid && load_time_ok;
        tick     = run && (presc_q == PRESC_LAST);
        advance  = tick && !load_ok;
        presc_d  = presc_q;
        if (load_ok) begin
            presc_d = '0;
        end else if (run) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
        alarm_d     = (alarm_set && alarm_time_ok) ? alarm_time : alarm_q;
        load_err_d  = (load_valid && !load_time_ok) || (alarm_set && !alarm_time_ok);
        tick_out_d  = advance;
        rollover_d  = carry[NUM_FIELDS];
        alarm_hit_d = tick_out_q && alarm_en && !load_ok && (time_out == alarm_q);
        // An ack landing with either the hit decision or the visible hit pulse cannot clear it.
        pending_d   = alarm_hit_d || alarm_hit_q || (pending_q && !alarm_ack);
    end

    assign carry[0] = advance;

    for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_field
        bcd_field_counter #(
            .MODULUS(field_modulus(g, HOUR_LIMIT))
        ) u_field (
            .clk      (clk),
            .resetn   (resetn),
            .carry_in (carry[g]),
            .carry_out(carry[g+1]),
            .load     (load_ok),
            .load_val (load_time[g*FIELD_W +: FIELD_W]),
            .value    (time_out[g*FIELD_W +: FIELD_W])
        );
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            presc_q     <= '0;
            alarm_q     <= '0;
            tick_out_q  <= 1'b0;
            rollover_q  <= 1'b0;
            alarm_hit_q <= 1'b0;
            pending_q   <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            alarm_q     <= alarm_d;
            tick_out_q  <= tick_out_d;
            rollover_q  <= rollover_d;
            alarm_hit_q <= alarm_hit_d;
            pending_q   <= pending_d;
            load_err_q  <= load_err_d;
        end
    end

    assign tick_out      = tick_out_q;
    assign rollover      = rollover_q;
    assign alarm_hit     = alarm_hit_q;
    assign alarm_pending = pending_q;
    assign load_err      = load_err_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Scoreboard bench: MM:SS (TICK_DIV=1) and HH:MM:SS (TICK_DIV=4) instances driven in lockstep
// against an integer-seconds reference model.
module tb_bcd_time_counter;

    localparam int HOURS = 24;

    typedef struct packed {
        logic        rst;
        logic        run;
        logic        lv;
        logic [23:0] lt;
        logic        aset;
        logic [23:0] at;
        logic        aen;
        logic        ack;
    } in_t;

    typedef struct packed {
        logic [23:0] tv;
        logic        tick;
        logic        roll;
        logic        hit;
        logic        pend;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    in_t in_a, in_b;

    logic [15:0] a_time;
    logic        a_tick, a_roll, a_hit, a_pend, a_err;
    logic [23:0] b_time;
    logic        b_tick, b_roll, b_hit, b_pend, b_err;

    bcd_time_counter #(.NUM_FIELDS(2), .TICK_DIV(1), .HOUR_LIMIT(HOURS)) dut_a (
        .clk(clk), .resetn(in_a.rst), .run(in_a.run),
        .load_valid(in_a.lv), .load_time(in_a.lt[15:0]),
        .alarm_set(in_a.aset), .alarm_time(in_a.at[15:0]),
        .alarm_en(in_a.aen), .alarm_ack(in_a.ack),
        .time_out(a_time), .tick_out(a_tick), .rollover(a_roll),
        .alarm_hit(a_hit), .alarm_pending(a_pend), .load_err(a_err)
    );

    bcd_time_counter #(.NUM_FIELDS(3), .TICK_DIV(4), .HOUR_LIMIT(HOURS)) dut_b (
        .clk(clk), .resetn(in_b.rst), .run(in_b.run),
        .load_valid(in_b.lv), .load_time(in_b.lt),
        .alarm_set(in_b.aset), .alarm_time(in_b.at),
        .alarm_en(in_b.aen), .alarm_ack(in_b.ack),
        .time_out(b_time), .tick_out(b_tick), .rollover(b_roll),
        .alarm_hit(b_hit), .alarm_pending(b_pend), .load_err(b_err)
    );

    // ---------------- reference model: time kept as integer seconds ----------------
    int m_secs [2];
    int m_presc[2];
    int m_alarm[2];
    bit m_tick [2];
    bit m_hit  [2];
    bit m_pend [2];

    function automatic int nfields(input int k);
        return (k == 0) ? 2 : 3;
    endfunction

    function automatic int tick_div(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    function automatic int period(input int k);
        return (k == 0) ? 3600 : HOURS * 3600;
    endfunction

    function automatic bit time_ok(input int k, input logic [23:0] v);
        int tens, ones, lim;
        for (int i = 0; i < nfields(k); i++) begin
            tens = int'(v[i*8+4 +: 4]);
            ones = int'(v[i*8 +: 4]);
            lim  = (i < 2) ? 60 : HOURS;
            if (tens > 9 || ones > 9 || tens * 10 + ones >= lim) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int time_secs(input int k, input logic [23:0] v);
        int s, w;
        s = 0;
        w = 1;
        for (int i = 0; i < nfields(k); i++) begin
            s += (int'(v[i*8+4 +: 4]) * 10 + int'(v[i*8 +: 4])) * w;
            w *= 60;
        end
        return s;
    endfunction

    function automatic logic [23:0] to_bcd(input int s);
        int hr, mn, sc;
        hr = s / 3600;
        mn = (s / 60) % 60;
        sc = s % 60;
        return {4'(hr / 10), 4'(hr % 10), 4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10)};
    endfunction

    task automatic model_step(input int k, input in_t i, output exp_t e);
        bit lok, aok, tick, adv, hit;
        e = '0;
        if (i.rst) begin
            m_secs[k]  = 0;
            m_presc[k] = 0;
            m_alarm[k] = 0;
            m_tick[k]  = 1'b0;
            m_hit[k]   = 1'b0;
            m_pend[k]  = 1'b0;
            return;
        end
        lok  = i.lv && time_ok(k, i.lt);
        aok  = i.aset && time_ok(k, i.at);
        tick = i.run && (m_presc[k] == tick_div(k) - 1);
        adv  = tick && !lok;
        hit  = m_tick[k] && i.aen && !lok && (m_secs[k] == m_alarm[k]);
        m_pend[k] = hit || m_hit[k] || (m_pend[k] && !i.ack);
        if (lok)        m_presc[k] = 0;
        else if (i.run) m_presc[k] = tick ? 0 : m_presc[k] + 1;
        if (lok)        m_secs[k] = time_secs(k, i.lt);
        else if (adv)   m_secs[k] = (m_secs[k] + 1) % period(k);
        if (aok)        m_alarm[k] = time_secs(k, i.at);
        m_tick[k] = adv;
        m_hit[k]  = hit;
        e.tv   = to_bcd(m_secs[k]);
        e.tick = adv;
        e.roll = adv && (m_secs[k] == 0);
        e.hit  = hit;
        e.pend = m_pend[k];
        e.err  = (i.lv && !time_ok(k, i.lt)) || (i.aset && !time_ok(k, i.at));
    endtask

    // ---------------- scoreboard ----------------
    exp_t qa[$];
    exp_t qb[$];
    int   tests = 0;
    int   fails = 0;
    int   mon_n = 0;

    task automatic check(input string name, input exp_t got, input exp_t exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got time=%h tick=%b roll=%b hit=%b pend=%b err=%b, expected time=%h tick=%b roll=%b hit=%b pend=%b err=%b",
                     name, mon_n, got.tv, got.tick, got.roll, got.hit, got.pend, got.err,
                     exp.tv, exp.tick, exp.roll, exp.hit, exp.pend, exp.err);
        end
    endtask

    always @(posedge clk) begin
        exp_t e, g;
        #1;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            g = {8'h00, a_time, a_tick, a_roll, a_hit, a_pend, a_err};
            check("dut_a", g, e);
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            g = {b_time, b_tick, b_roll, b_hit, b_pend, b_err};
            check("dut_b", g, e);
        end
        mon_n++;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        exp_t e;
        model_step(0, in_a, e);
        qa.push_back(e);
        model_step(1, in_b, e);
        qb.push_back(e);
        @(negedge clk);
    endtask

    function automatic logic [23:0] rand_time(input int k);
        logic [23:0] mask;
        mask = (k == 0) ? 24'h00ffff : 24'hffffff;
        case ($urandom % 4)
            0:       return to_bcd(int'($urandom % period(k)));
            1:       return 24'($urandom) & mask;
            2:       return to_bcd(period(k) - 1 - int'($urandom % 3));
            default: return to_bcd((m_secs[k] + int'($urandom % 6)) % period(k));
        endcase
    endfunction

    task automatic rand_in(input int k, output in_t i);
        i      = '0;
        i.rst  = ($urandom % 400) == 0;
        i.run  = ($urandom % 8) != 0;
        i.aen  = ($urandom % 4) != 0;
        i.ack  = ($urandom % 12) == 0;
        if ($urandom % 20 == 0) begin
            i.lv = 1'b1;
            i.lt = rand_time(k);
        end
        if ($urandom % 30 == 0) begin
            i.aset = 1'b1;
            i.at   = rand_time(k);
        end
    endtask

    task automatic drive_b(input int c);
        in_b     = '0;
        in_b.run = 1'b1;
        in_b.aen = 1'b1;
        case (c)
            0:  begin in_b.lv = 1'b1; in_b.lt = 24'h235958; end
            24: begin in_b.lv = 1'b1; in_b.lt = 24'h240000; end
            30, 31, 32: in_b.run = 1'b0;
            41: begin in_b.lv = 1'b1; in_b.lt = 24'h00005a; end
            45: begin
                in_b.lv = 1'b1; in_b.lt = 24'h000010;
                in_b.aset = 1'b1; in_b.at = 24'h006000;
            end
            50: begin in_b.aset = 1'b1; in_b.at = 24'h000016; end
            90: in_b.ack = 1'b1;
            98: in_b.rst = 1'b1;
            default: ;
        endcase
        if (c >= 120) rand_in(1, in_b);
    endtask

    initial begin
        bit done42;
        in_a     = '0;
        in_b     = '0;
        in_a.rst = 1'b1;
        in_b.rst = 1'b1;
        @(negedge clk);
        step();
        step();

        // One full hour on the MM:SS instance with an alarm at 00:05.
        for (int c = 0; c < 3620; c++) begin
            in_a     = '0;
            in_a.run = 1'b1;
            in_a.aen = 1'b1;
            if (c == 0) begin
                in_a.aset = 1'b1;
                in_a.at   = 24'h000005;
            end
            if (c == 100) in_a.ack = 1'b1;
            // On the second pass through 00:05, ack lands on the hit itself.
            if (c > 3000) in_a.ack = m_tick[0] && (m_secs[0] == m_alarm[0]);
            drive_b(c);
            step();
        end

        done42 = 1'b0;
        for (int c = 0; c < 2500; c++) begin
            in_a     = '0;
            in_a.run = 1'b1;
            in_a.aen = 1'b1;
            if (c == 0) begin
                in_a.lv = 1'b1;
                in_a.lt = 24'h000005;
            end
            if (c >= 60 && c < 63) in_a.run = 1'b0;
            if (!done42 && m_secs[0] == 42) begin
                in_a.rst = 1'b1;
                done42   = 1'b1;
            end
            if (c >= 100) rand_in(0, in_a);
            rand_in(1, in_b);
            step();
        end

        in_a = '0;
        in_b = '0;
        step();
        step();
        repeat (2) @(posedge clk);
        #2;
        tests++;
        if (qa.size() != 0 || qb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d/%0d expectations left, required 0/0", qa.size(), qb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_time_counter.md
BCD_TIME_COUNTER -- requirements
Module: bcd_time_counter

Interface
REQ-001 The block SHALL have parameter NUM_FIELDS, default 2, giving the number of 8-bit packed-BCD fields (2 = MM:SS, 3 = HH:MM:SS).
REQ-002 The block SHALL have parameter TICK_DIV, default 1, giving the clk cycles per one-second tick (TICK_DIV ≥ 1).
REQ-003 The block SHALL have parameter HOUR_LIMIT, default 24, giving the hour-field modulus, used only when NUM_FIELDS=3.
REQ-004 The block SHALL define W = 8*NUM_FIELDS; the most significant field is leftmost and seconds are in bits [7:0].
REQ-005 The port list SHALL be, in order: clk  in  1  sole clock, rising edge.
REQ-006 resetn  in  1  reset; synchronous and active-high despite the name.
REQ-007 run  in  1  enables the prescaler and counting.
REQ-008 load_valid  in  1  one-cycle request to load load_time.
REQ-009 load_time  in  W  packed-BCD value to load.
REQ-010 alarm_set  in  1  one-cycle request to latch alarm_time.
REQ-011 alarm_time  in  W  packed-BCD alarm value.
REQ-012 alarm_en  in  1  enables alarm matching.
REQ-013 alarm_ack  in  1  clears alarm_pending.
REQ-014 time_out  out  W  current time, registered.
REQ-015 tick_out  out  1  one-cycle pulse when time_out advances.
REQ-016 rollover  out  1  one-cycle pulse when time_out wraps to all zeros.
REQ-017 alarm_hit  out  1  one-cycle pulse on an alarm match.
REQ-018 alarm_pending  out  1  sticky alarm flag.
REQ-019 load_err  out  1  one-cycle pulse when a load or alarm_set is rejected.

Function
REQ-020 Prescaler SHALL count 0..TICK_DIV-1 while run=1, hold its value while run=0, and raise an internal tick in the cycle where count==TICK_DIV-1 and run=1; with TICK_DIV=1 a tick occurs every run=1 cycle.
REQ-021 On a tick, time_out SHALL update on the same clk edge: the seconds ones digit increments; each digit carries on wrap 9→0 (tens digits of seconds and minutes wrap 5→0).
REQ-022 Hours field (NUM_FIELDS=3) SHALL wrap HOUR_LIMIT-1 → 00; the top field's wrap SHALL assert rollover together with tick_out (e.g. 59:59→00:00, 23:59:59→00:00:00).
REQ-023 A load is valid iff every digit ≤9, seconds/minutes tens ≤5, and the hours value < HOUR_LIMIT.
REQ-024 A valid load SHALL set time_out=load_time on the next edge, clear the prescaler, and suppress any same-cycle tick (load wins; no tick_out, rollover or alarm_hit that cycle).
REQ-025 An invalid load SHALL leave all state unchanged except load_err=1 for one cycle; normal ticking continues.
REQ-026 alarm_set with a valid value SHALL latch alarm_time into an internal alarm register; an invalid value SHALL pulse load_err and leave the register unchanged.
REQ-027 alarm_hit SHALL pulse in the cycle after a tick-driven update makes time_out equal the alarm register while alarm_en=1; loads SHALL NOT cause hits.
REQ-028 alarm_pending SHALL set on alarm_hit and clear on alarm_ack; a simultaneous hit and ack SHALL leave it set.
REQ-029 alarm_en=0 SHALL block new hits but SHALL NOT clear alarm_pending.
REQ-030 Simultaneous load_valid and alarm_set SHALL both be processed; load_err SHALL pulse if either is invalid.

Reset
REQ-031 While resetn=1 at a clk edge, time_out, prescaler, alarm register, alarm_pending, tick_out, rollover, alarm_hit and load_err SHALL all become 0; reset overrides every other input.
REQ-032 Reset mid-count SHALL discard the partial prescaler count; counting SHALL resume from 0 on the first edge after resetn=0 with run=1.

Structure
REQ-033 Shared package time_pkg SHALL hold FIELD_W=8, SEC_MAX=59, MIN_MAX=59, and a BCD-digit-valid constant/function.
REQ-034 A sub-module bcd_field_counter SHALL implement one two-digit field, with parameter MODULUS and ports carry_in, carry_out, load, load_val and value; it is instantiated NUM_FIELDS times.

Verification
REQ-035 NUM_FIELDS=2, TICK_DIV=1, run=1 from reset -> time_out 0000, 0001, ... 0059, 0100; after 3600 ticks, time_out=0000 with rollover=1 on that cycle only.
REQ-036 TICK_DIV=4, run toggled 0 for 3 cycles mid-count -> tick_out spacing is exactly 4 run=1 cycles; time_out is held while run=0.
REQ-037 NUM_FIELDS=3, load 235958, run -> 235959, then 000000 with rollover=1; load 240000 -> load_err=1 and time_out unchanged.
REQ-038 alarm_set 0005, alarm_en=1, counting from 0000 -> alarm_hit one cycle after time_out=0005; pending stays 1 until alarm_ack; ack coinciding with a new hit leaves pending at 1.
REQ-039 load_valid with 0005 while alarm=0005 -> no alarm_hit; a load coinciding with a tick -> loaded value appears, no tick_out.
REQ-040 resetn=1 for one cycle at time 0042 with prescaler mid-count -> all outputs 0 on the next cycle; the first tick occurs TICK_DIV cycles after release.
